// File: rtl/mem_request_unit.sv
// Load/store initiator: effective address, alignment/range check, byte/half RMW and load lane extraction.
// Latency from accept: error 1, word store 2, load 3, sub-word store 4 cycles; response held until i_rsp_ready.
module mem_request_unit #(
  parameter int ADDR_LIMIT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_is_store,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_base,
  input  logic [31:0] i_req_offset,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_tag,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [4:0]  o_rsp_tag,
  output logic        o_rsp_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  output logic        o_mem_re,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_MERGE, S_WRITE, S_RESP} state_t;

  typedef struct packed {
    logic        is_store;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [1:0]  lane;
    logic [15:0] wdata_lo;
  } req_t;

  localparam logic [31:0] LAST_WORD = 32'(ADDR_LIMIT - 4);

  state_t      r_state;
  state_t      w_state_nxt;
  req_t        r_req;
  logic [31:0] r_rsp_data;
  logic [4:0]  r_rsp_tag;
  logic        r_rsp_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic [31:0] w_ea;
  logic [31:0] w_aligned;
  logic        w_err;
  logic        w_accept;
  logic        w_word_store;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_ea         = i_req_base + i_req_offset;
  assign w_aligned    = {w_ea[31:2], 2'b00};
  assign w_accept     = (r_state == S_IDLE) && i_req_valid;
  assign w_word_store = i_req_is_store && (i_req_size == 2'd2);

  always_comb begin
    w_err = 1'b0;
    if (i_req_size == 2'd3) w_err = 1'b1;
    if (i_req_size == 2'd1 && w_ea[0]) w_err = 1'b1;
    if (i_req_size == 2'd2 && w_ea[1:0] != 2'b00) w_err = 1'b1;
    if (w_aligned > LAST_WORD) w_err = 1'b1;
  end

  // Lane extraction for loads and lane replacement for sub-word stores, both from the captured word.
  assign w_shifted = i_mem_rdata >> {r_req.lane, 3'b000};

  always_comb begin
    w_load = i_mem_rdata;
    case (r_req.size)
      2'd0:    w_load = {{24{~r_req.is_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_load = {{16{~r_req.is_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = i_mem_rdata;
    endcase
  end

  always_comb begin
    w_merged = i_mem_rdata;
    if (r_req.size == 2'd0) w_merged[{r_req.lane, 3'b000} +: 8] = r_req.wdata_lo[7:0];
    else                    w_merged[{r_req.lane[1], 4'b0000} +: 16] = r_req.wdata_lo;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (w_err)             w_state_nxt = S_RESP;
          else if (w_word_store) w_state_nxt = S_WRITE;
          else                   w_state_nxt = S_READ;
        end
      end
      S_READ:  w_state_nxt = S_MERGE;
      S_MERGE: w_state_nxt = r_req.is_store ? S_WRITE : S_RESP;
      S_WRITE: w_state_nxt = S_RESP;
      S_RESP:  if (i_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_req       <= '0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_req.is_store    <= i_req_is_store;
        r_req.size        <= i_req_size;
        r_req.is_unsigned <= i_req_unsigned;
        r_req.lane        <= w_ea[1:0];
        r_req.wdata_lo    <= i_req_wdata[15:0];
        r_rsp_tag         <= i_req_tag;
        r_rsp_err         <= w_err;
        r_rsp_data        <= '0;
        // Error requests leave the memory-side address/data untouched.
        if (!w_err) begin
          r_mem_addr <= w_aligned;
          if (w_word_store) r_mem_wdata <= i_req_wdata;
        end
      end
      if (r_state == S_MERGE) begin
        if (r_req.is_store) r_mem_wdata <= w_merged;
        else                r_rsp_data  <= w_load;
      end
    end
  end

  // Outputs are forced low while reset is asserted so no strobe can escape in the reset cycle.
  assign o_req_ready = i_rst_n && (r_state == S_IDLE);
  assign o_rsp_valid = i_rst_n && (r_state == S_RESP);
  assign o_mem_re    = i_rst_n && (r_state == S_READ);
  assign o_mem_we    = i_rst_n && (r_state == S_WRITE);
  assign o_rsp_data  = i_rst_n ? r_rsp_data  : '0;
  assign o_rsp_tag   = i_rst_n ? r_rsp_tag   : '0;
  assign o_rsp_err   = i_rst_n ? r_rsp_err   : 1'b0;
  assign o_mem_addr  = i_rst_n ? r_mem_addr  : '0;
  assign o_mem_wdata = i_rst_n ? r_mem_wdata : '0;

endmodule

// File: tb/tb_mem_request_unit.sv
// Bench for mem_request_unit: directed cases plus random requests against a byte-array reference model.
module tb_mem_request_unit;

  localparam int LIMIT = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_base, req_offset, req_wdata;
  logic [4:0]  req_tag;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data, mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  rsp_tag;
  logic        mem_we, mem_re;
  logic        mem_clear;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] env_mem [0:LIMIT-1];
  logic [7:0] ref_mem [0:LIMIT-1];

  always #5 clk = ~clk;

  mem_request_unit #(.ADDR_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_is_store(req_is_store), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
    .i_req_base(req_base), .i_req_offset(req_offset), .i_req_wdata(req_wdata), .i_req_tag(req_tag),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_rsp_tag(rsp_tag), .o_rsp_err(rsp_err),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .o_mem_re(mem_re),
    .i_mem_rdata(mem_rdata)
  );

  // Data memory: little-endian word writes, registered reads.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < LIMIT; i++) env_mem[i] <= 8'h00;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_we)
        for (int i = 0; i < 4; i++) env_mem[int'(mem_addr[9:0]) + i] <= mem_wdata[8*i +: 8];
      if (mem_re)
        mem_rdata <= {env_mem[int'(mem_addr[9:0]) + 3], env_mem[int'(mem_addr[9:0]) + 2],
                      env_mem[int'(mem_addr[9:0]) + 1], env_mem[int'(mem_addr[9:0])]};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  task automatic scramble();
    req_is_store = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_base     = $urandom;
    req_offset   = $urandom;
    req_wdata    = $urandom;
    req_tag      = 5'($urandom);
  endtask

  // One request end to end: model prediction, handshake, strobe/latency/response checks, handoff.
  task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd,
                        input logic [4:0] tag, input int hold);
    logic [31:0] ea, al, wrd, sh, exp_data, exp_wword;
    logic        exp_err, overlap;
    int lat, exp_re, exp_we, exp_we_cyc, nb, re_cnt, we_cnt, we_cyc, cyc, k;
    ea  = base + off;
    al  = {ea[31:2], 2'b00};
    exp_err = (sz == 2'd3) || (sz == 2'd1 && ea[0]) || (sz == 2'd2 && ea[1:0] != 2'b00) ||
              (al > 32'(LIMIT - 4));
    exp_data = 32'h0; exp_wword = 32'h0; exp_re = 0; exp_we = 0; exp_we_cyc = 0;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (exp_err) begin
      lat = 1;
    end else if (!st) begin
      lat = 3; exp_re = 1;
      wrd = ref_word(int'(al));
      sh  = wrd >> (8 * int'(ea[1:0]));
      if (sz == 2'd0)      exp_data = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      else if (sz == 2'd1) exp_data = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      else                 exp_data = wrd;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[int'(ea) + i] = wd[8*i +: 8];
      exp_wword = ref_word(int'(al));
      exp_we = 1;
      if (sz == 2'd2) begin lat = 2; exp_we_cyc = 1; end
      else begin lat = 4; exp_re = 1; exp_we_cyc = 3; end
    end

    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns;
    req_base = base; req_offset = off; req_wdata = wd; req_tag = tag;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    scramble();

    re_cnt = 0; we_cnt = 0; we_cyc = 0; overlap = 1'b0; cyc = 1;
    while (cyc <= 20) begin
      if (mem_re && mem_we) overlap = 1'b1;
      if (mem_re) begin
        re_cnt++;
        chk("re_cycle", cyc, 1);
        chk("re_addr", mem_addr, al);
      end
      if (mem_we) begin
        we_cnt++; we_cyc = cyc;
        chk("we_addr", mem_addr, al);
        chk("we_data", mem_wdata, exp_wword);
      end
      if (rsp_valid) break;
      @(negedge clk);
      cyc++;
    end
    chk("rsp_latency", cyc, lat);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_tag", {27'h0, rsp_tag}, {27'h0, tag});
    chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
    chk("re_count", re_cnt, exp_re);
    chk("we_count", we_cnt, exp_we);
    if (exp_we != 0) chk("we_cycle", we_cyc, exp_we_cyc);
    chk("strobe_overlap", {31'h0, overlap}, 32'h0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, rsp_valid}, 32'h1);
      chk("hold_data", rsp_data, exp_data);
      chk("hold_tag", {27'h0, rsp_tag}, {27'h0, tag});
      chk("hold_ready", {31'h0, req_ready}, 32'h0);
      chk("hold_strobes", {30'h0, mem_re, mem_we}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", {31'h0, rsp_valid}, 32'h0);
    chk("post_ready", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h0);
    chk({tag, "_outs"}, {27'h0, rsp_valid, rsp_err, mem_we, mem_re, 1'b0}, 32'h0);
    chk({tag, "_data"}, rsp_data | mem_addr | mem_wdata | {27'h0, rsp_tag}, 32'h0);
  endtask

  initial begin
    logic [31:0] rb, ro;
    rst_n = 1'b0; mem_clear = 1'b1; rsp_ready = 1'b0; req_valid = 1'b0;
    scramble();
    for (int i = 0; i < LIMIT; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1; mem_clear = 1'b0;
    #1;
    chk("reset_rel_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_rel_outs", {27'h0, rsp_valid, rsp_err, mem_we, mem_re, 1'b0}, 32'h0);

    // Word store then load back.
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h4, 32'hDEADBEEF, 5'd1, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h4, 32'h0, 5'd2, 0);
    // Extension cases on 0x80FF7F01 at 0x10.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80FF7F01, 5'd3, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h3, 32'h0, 5'd4, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h0, 5'd5, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'h0, 5'd6, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h2, 32'h0, 5'd7, 1);
    do_req(1'b0, 2'd1, 1'b1, 32'h14, 32'hFFFFFFFE, 32'h0, 5'd8, 0);
    // Sub-word read-modify-write.
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 32'h11223344, 5'd9, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h20, 32'h2, 32'hFFFFFFAB, 5'd10, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 5'd11, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h0, 32'h1234CAFE, 5'd12, 2);
    do_req(1'b0, 2'd2, 1'b1, 32'h20, 32'h0, 32'h0, 5'd13, 0);
    // Errors and the range boundary.
    do_req(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 32'h0, 5'd14, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h2, 32'h55555555, 5'd15, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h3FD, 32'h0, 32'h0, 5'd16, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0, 5'd17, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h30, 32'h0, 32'h0, 5'd18, 0);
    do_req(1'b1, 2'd3, 1'b0, 32'h30, 32'h0, 32'h77, 5'd19, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h3FC, 32'h0, 32'hA5A55A5A, 5'd20, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0, 32'h0, 5'd21, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'hFFFFFFFC, 32'h0, 5'd22, 0);
    // Response back-pressure.
    do_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'h0, 5'd23, 5);

    // Reset during the MERGE cycle of a byte store: no write, no response.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_base = 32'h20; req_offset = 32'h1; req_wdata = 32'h000000EE; req_tag = 5'd24;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_read_re", {31'h0, mem_re}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_merge");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk_quiet("rst_hold");
    end
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rel_outs", rsp_data | mem_addr | mem_wdata | {27'h0, rsp_tag} |
        {28'h0, rsp_valid, rsp_err, mem_we, mem_re}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_after_quiet", {30'h0, rsp_valid, mem_we}, 32'h0);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 5'd25, 0);

    // Random traffic, mostly in range, with some wrap and overrun.
    for (int n = 0; n < 120; n++) begin
      rb = 32'($urandom_range(0, 1100));
      ro = 32'($urandom_range(0, 64)) - 32'd32;
      do_req(1'($urandom), ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
             1'($urandom), rb, ro, $urandom, 5'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
